// File: rtl/task_pkg.sv
// task_pkg: shared task-word layout and task-type encodings for the enqueue and distributor blocks
package task_pkg;

    localparam int TASK_PTW           = 16;
    localparam int TASK_TREE_NUM_BITS = 2;

    localparam logic TASK_POP  = 1'b0;
    localparam logic TASK_PUSH = 1'b1;

    typedef struct packed {
        logic                          is_push;
        logic [TASK_TREE_NUM_BITS-1:0] tree_id;
        logic [TASK_PTW-1:0]           data;
    } task_word_t;

endpackage

// File: rtl/task_fifo.sv
// task_fifo: single-clock FIFO with registered read port, occupancy count, full and empty flags
module task_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rd,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][W-1:0] mem_d, mem_q;
    logic [AW-1:0]           wptr_d, wptr_q;
    logic [AW-1:0]           rptr_d, rptr_q;
    logic [CW-1:0]           count_d, count_q;
    logic [W-1:0]            rdata_d, rdata_q;
    logic                    do_wr, do_rd;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_rdata = rdata_q;

    // next-state for storage, pointers, count and the registered read word; reads see only pre-write contents
    always_comb begin
        do_wr   = i_wr & ~o_full;
        do_rd   = i_rd & ~o_empty;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        rdata_d = rdata_q;
        if (do_wr) begin
            mem_d[wptr_q] = i_wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rdata_d = mem_q[rptr_q];
            rptr_d  = rptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_wr) - CW'(do_rd);
    end

    // state registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: rtl/task_enqueue.sv
// task_enqueue: per-slot round-robin enqueue of tree push/pop tasks with occupancy policing; TASK_ENQ_STATS_EN adds per-slot counters
module task_enqueue
    import task_pkg::*;
#(
    parameter int PTW           = 16,
    parameter int LEVEL         = 4,
    parameter int TREE_NUM      = 4,
    parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
    parameter int FIFO_DEPTH    = 8,
    parameter int TREE_CAP      = 1023,
    parameter int CNT_BITS      = $clog2(TREE_CAP + 1)
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [TREE_NUM-1:0]                       i_req_valid,
    input  logic [TREE_NUM-1:0]                       i_req_push,
    input  logic [TREE_NUM-1:0][PTW-1:0]              i_req_data,
    output logic [TREE_NUM-1:0]                       o_req_ready,
    output logic [TREE_NUM-1:0]                       o_req_err,
    input  logic [LEVEL-1:0]                          i_pop_TaskFIFO,
    output logic [LEVEL-1:0][PTW+TREE_NUM_BITS:0]     o_TaskFIFO_data,
    output logic [LEVEL-1:0]                          o_TaskFIFO_empty,
    output logic [TREE_NUM-1:0][CNT_BITS-1:0]         o_tree_cnt
`ifdef TASK_ENQ_STATS_EN
    ,
    output logic [LEVEL-1:0][31:0]                    o_stat_push_cnt,
    output logic [LEVEL-1:0][31:0]                    o_stat_pop_cnt,
    output logic [LEVEL-1:0][31:0]                    o_stat_err_cnt
`endif
);

    localparam int TW = PTW + TREE_NUM_BITS + 1;

    logic [LEVEL-1:0]                     full;
    logic [LEVEL-1:0]                     wr;
    logic [LEVEL-1:0][TW-1:0]             wdata;
    logic [TREE_NUM-1:0]                  grant;
    logic [TREE_NUM-1:0]                  sel;
    logic [TREE_NUM-1:0]                  reject;
    int                                   best;
    logic [LEVEL-1:0][TREE_NUM_BITS-1:0]  rr_ptr_d, rr_ptr_q;
    logic [TREE_NUM-1:0]                  err_d, err_q;
    logic [TREE_NUM-1:0][CNT_BITS-1:0]    cnt_d, cnt_q;

    assign o_req_err  = err_q;
    assign o_tree_cnt = cnt_q;

    // per-slot round robin: the valid tree nearest at or after the pointer wins; pointer moves past the winner
    always_comb begin
        grant    = '0;
        sel      = '0;
        best     = 0;
        rr_ptr_d = rr_ptr_q;
        for (int l = 0; l < LEVEL; l++) begin
            sel  = '0;
            best = TREE_NUM;
            for (int t = 0; t < TREE_NUM; t++) begin
                if (t % LEVEL == l && i_req_valid[t] &&
                    (t + TREE_NUM - int'(rr_ptr_q[l])) % TREE_NUM < best) begin
                    best        = (t + TREE_NUM - int'(rr_ptr_q[l])) % TREE_NUM;
                    sel         = '0;
                    sel[t]      = 1'b1;
                    rr_ptr_d[l] = TREE_NUM_BITS'((t + 1) % TREE_NUM);
                end
            end
            grant = grant | sel;
        end
    end

    // handshake, occupancy policing and task-word packing; rejected requests are consumed without a write
    always_comb begin
        o_req_ready = '0;
        reject      = '0;
        err_d       = '0;
        wr          = '0;
        wdata       = '0;
        cnt_d       = cnt_q;
        for (int t = 0; t < TREE_NUM; t++) begin
            o_req_ready[t] = grant[t] & ~full[t % LEVEL];
            reject[t]      = (i_req_push[t] == TASK_PUSH) ? (cnt_q[t] == CNT_BITS'(TREE_CAP))
                                                          : (cnt_q[t] == '0);
            err_d[t]       = o_req_ready[t] & reject[t];
            if (o_req_ready[t] && !reject[t]) begin
                wr[t % LEVEL]    = 1'b1;
                wdata[t % LEVEL] = {i_req_push[t], TREE_NUM_BITS'(t),
                                    (i_req_push[t] == TASK_PUSH) ? i_req_data[t] : {PTW{1'b0}}};
                cnt_d[t]         = (i_req_push[t] == TASK_PUSH) ? cnt_q[t] + 1'b1 : cnt_q[t] - 1'b1;
            end
        end
    end

    // arbiter pointers, error pulses and committed occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= '0;
            err_q    <= '0;
            cnt_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar g = 0; g < LEVEL; g++) begin : g_slot
        task_fifo #(
            .W     (TW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_wr    (wr[g]),
            .i_wdata (wdata[g]),
            .i_rd    (i_pop_TaskFIFO[g]),
            .o_rdata (o_TaskFIFO_data[g]),
            .o_empty (o_TaskFIFO_empty[g]),
            .o_full  (full[g])
        );
    end

`ifdef TASK_ENQ_STATS_EN
    logic [LEVEL-1:0][31:0] push_cnt_d, push_cnt_q;
    logic [LEVEL-1:0][31:0] pop_cnt_d, pop_cnt_q;
    logic [LEVEL-1:0][31:0] err_cnt_d, err_cnt_q;

    assign o_stat_push_cnt = push_cnt_q;
    assign o_stat_pop_cnt  = pop_cnt_q;
    assign o_stat_err_cnt  = err_cnt_q;

    // saturating per-slot tallies of accepted pushes, accepted pops and rejections
    always_comb begin
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        err_cnt_d  = err_cnt_q;
        for (int l = 0; l < LEVEL; l++) begin
            if (wr[l] && wdata[l][TW-1] == TASK_PUSH && push_cnt_q[l] != '1) push_cnt_d[l] = push_cnt_q[l] + 1'b1;
            if (wr[l] && wdata[l][TW-1] == TASK_POP && pop_cnt_q[l] != '1) pop_cnt_d[l] = pop_cnt_q[l] + 1'b1;
        end
        for (int t = 0; t < TREE_NUM; t++) begin
            if (err_d[t] && err_cnt_q[t % LEVEL] != '1) err_cnt_d[t % LEVEL] = err_cnt_q[t % LEVEL] + 1'b1;
        end
    end

    // statistics registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end
`endif

endmodule

// File: doc/task_enqueue.md
Name: task_enqueue

Overview:
- Producer side of the per-level TaskFIFO interface; it feeds the RPU task distributor.
- Accepts push/pop requests from TREE_NUM tree clients and statically maps each tree to one of LEVEL task slots.
- Round-robin arbitrates among the trees sharing a slot, packs the task word and writes it into per-slot FIFOs.
- Exposes pop/data/empty per slot; also polices per-tree occupancy so that no pop is issued to an empty tree and no push to a full tree.

Parameters:
- PTW, 16, payload width.
- LEVEL, 4, number of task slots/FIFOs (one per RPU).
- TREE_NUM, 4, number of tree clients.
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width.
- FIFO_DEPTH, 8, entries per slot FIFO; must be a power of 2, at least 2.
- TREE_CAP, 1023, maximum elements held per tree.
- CNT_BITS, $clog2(TREE_CAP+1), occupancy counter width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req_valid  in  [TREE_NUM-1:0]  per-tree request valid.
- i_req_push  in  [TREE_NUM-1:0]  request type: 1 push, 0 pop.
- i_req_data  in  [PTW-1:0] x TREE_NUM  push payload; ignored for pop.
- o_req_ready  out  [TREE_NUM-1:0]  request accepted this cycle when valid&ready.
- o_req_err  out  [TREE_NUM-1:0]  one-cycle pulse: request consumed but rejected.
- i_pop_TaskFIFO  in  [LEVEL-1:0]  per-slot FIFO pop.
- o_TaskFIFO_data  out  [PTW+TREE_NUM_BITS:0] x LEVEL  task word {type, treeId, data}.
- o_TaskFIFO_empty  out  [LEVEL-1:0]  slot FIFO empty.
- o_tree_cnt  out  [CNT_BITS-1:0] x TREE_NUM  committed per-tree occupancy.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: FIFO pointers and counts 0; o_TaskFIFO_empty all 1; o_TaskFIFO_data 0; o_req_err 0; o_tree_cnt 0; arbiter pointers 0. Reset asserted mid-operation discards all queued tasks on the next edge.
- Slot mapping: slot(t) = t mod LEVEL, fixed.
- Arbitration: per slot, round-robin over the trees mapped to it with i_req_valid=1. At most one grant per slot per cycle. After a grant, the pointer moves to the granted tree+1, wrapping among that slot's trees.
- Ready: o_req_ready[t] = granted[t] & slot FIFO not full. Full is computed from the registered count. A same-cycle pop does not free the entry.
- Policing, evaluated on grant:
  - push with cnt==TREE_CAP: reject.
  - pop with cnt==0: reject.
  - A rejected request is still consumed (ready=1) but no FIFO write occurs, and o_req_err[t] pulses on the next cycle.
- Committed occupancy: an accepted push increments cnt and an accepted pop decrements it, visible the next cycle. Pops are counted at enqueue, not at RPU completion.
- Task word: {i_req_push, t[TREE_NUM_BITS-1:0], push ? i_req_data : '0}.
- Slot FIFO read side:
  - Registered read: o_TaskFIFO_data updates exactly one cycle after a cycle with i_pop_TaskFIFO=1 and the FIFO non-empty, then holds until the next such pop.
  - Pop while empty is ignored; data and pointers are unchanged.
- Slot FIFO write/empty timing:
  - A write becomes visible (empty deasserts) the cycle after the write.
  - Simultaneous write and pop: both occur and the count is unchanged.
  - A write into an empty FIFO never bypasses to the data output.
- Pointers: wrap modulo FIFO_DEPTH. The count is FIFO_DEPTH+1 states wide so full and empty are unambiguous.
- Ordering: tasks of one tree keep issue order because they always use the same slot.

Optional Feature:
- Macro: TASK_ENQ_STATS_EN.
- Defined: adds o_stat_push_cnt, o_stat_pop_cnt and o_stat_err_cnt, each 32 bits x LEVEL.
  - Per slot, these count accepted pushes, accepted pops and rejections respectively.
  - Counters saturate at all-ones and clear on i_rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package task_pkg holds:
  - typedef task_word_t as a packed {logic is_push; logic [TREE_NUM_BITS-1:0] tree_id; logic [PTW-1:0] data}.
  - constants TASK_POP=1'b0 and TASK_PUSH=1'b1.
  - The distributor consumes the same typedef.
- Sub-module: task_fifo, a single-clock FIFO with registered read, count, full and empty, instantiated LEVEL times.

Test Plan:
- Empty pop: reset, then tree 1 issues pop → o_req_ready[1]=1, o_req_err[1] pulses next cycle, o_TaskFIFO_empty[1] stays 1, o_tree_cnt[1]=0.
- Single push read-back: tree 0 pushes 0x00AB → empty[0]=0 next cycle. Pop slot 0 → o_TaskFIFO_data[0]={1,0,0x00AB} one cycle later, empty[0]=1.
- Arbitration with LEVEL=2, TREE_NUM=4: trees 0 and 2 push continuously → slot 0 grants alternate 0,2,0,2. FIFO contents interleave in grant order.
- Full FIFO (FIFO_DEPTH=4): five pushes to slot 3 with no pops → 5th push waits with ready=0. Pop then push in the same cycle → count stays 4, entry accepted the next cycle.
- TREE_CAP=2: three pushes for tree 2 → third gets err, cnt=2. One pop → cnt=1, FIFO holds {1,2,d0},{1,2,d1},{0,2,0}.
- Mid-operation reset: reset asserted with 3 entries queued → next cycle all empty=1, all cnt=0, data=0. Stats counters (if enabled) = 0.
